// File: rtl/nf10_axis_pkg.sv
// nf10_axis_pkg: shared FSM states, tuser field offsets and default widths for the 10G rx guard.
package nf10_axis_pkg;
    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
    localparam int TUSER_LEN_LO = 0;
    localparam int TUSER_LEN_HI = 15;
    localparam int TUSER_SRC_LO = 16;
    localparam int TUSER_SRC_HI = 23;
    localparam int TUSER_DST_LO = 24;
    localparam int TUSER_DST_HI = 31;
    localparam int DEF_DATA_WIDTH = 256;
    localparam int DEF_TUSER_WIDTH = 128;
    localparam int DEF_MAX_BEATS = 48;
endpackage

// File: rtl/nf10_axis_skid.sv
// nf10_axis_skid: two-entry AXI-Stream skid buffer with fully registered outputs.
module nf10_axis_skid #(
    parameter int DATA_WIDTH = 256,
    parameter int TUSER_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tstrb,
    input  logic [TUSER_WIDTH-1:0]  s_tuser,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    output logic                    s_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tstrb,
    output logic [TUSER_WIDTH-1:0]  m_tuser,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    input  logic                    m_tready
);
    localparam int W = DATA_WIDTH + DATA_WIDTH/8 + TUSER_WIDTH + 1;
    logic [W-1:0] in_pl, out_pl, skid_pl;
    logic         skid_valid, s_fire;
    assign in_pl    = {s_tdata, s_tstrb, s_tuser, s_tlast};
    assign s_tready = !skid_valid && !rst;
    assign s_fire   = s_tvalid && s_tready;
    assign {m_tdata, m_tstrb, m_tuser, m_tlast} = out_pl;
    // The skid entry only fills when the output register is stalled, so input is refused while it is occupied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tvalid   <= 1'b0;
            skid_valid <= 1'b0;
            out_pl     <= '0;
            skid_pl    <= '0;
        end else if (!m_tvalid || m_tready) begin
            m_tvalid   <= skid_valid || s_fire;
            out_pl     <= skid_valid ? skid_pl : (s_fire ? in_pl : out_pl);
            skid_valid <= 1'b0;
        end else if (s_fire) begin
            skid_valid <= 1'b1;
            skid_pl    <= in_pl;
        end
    end
endmodule

// File: rtl/nf10_axis_rx_guard.sv
// nf10_axis_rx_guard: truncates oversize rx packets and fills in a default source port.
// Optional NF10_RX_GUARD_STATS_EN adds packet and truncation counters.
module nf10_axis_rx_guard
    import nf10_axis_pkg::*;
#(
    parameter int         C_AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int         C_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
    parameter int         C_MAX_BEATS        = DEF_MAX_BEATS,
    parameter logic [7:0] C_DEFAULT_SRC_PORT = 8'h40
) (
    input  logic                             axi_aclk,
    input  logic                             axi_reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic                             s_axis_tvalid,
    input  logic                             s_axis_tlast,
    output logic                             s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    input  logic                             m_axis_tready
`ifdef NF10_RX_GUARD_STATS_EN
    ,
    output logic [31:0]                      pkt_count,
    output logic [31:0]                      trunc_count
`endif
);
    localparam int BW = $clog2(C_MAX_BEATS) + 1;
    localparam logic [BW-1:0] MAX = BW'(C_MAX_BEATS);
    state_t                        state;
    logic [BW-1:0]                 beats, beat_num;
    logic                          skid_ready, accept, trunc;
    logic [C_AXIS_TUSER_WIDTH-1:0] fwd_user;
    assign beat_num      = (state == IDLE) ? BW'(1) : beats + BW'(1);
    assign s_axis_tready = (state == DROP) ? !axi_reset : skid_ready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign trunc         = accept && state != DROP && beat_num == MAX && !s_axis_tlast;
    always_comb begin
        fwd_user = s_axis_tuser;
        if (state == IDLE && s_axis_tuser[TUSER_SRC_HI:TUSER_SRC_LO] == 8'h00)
            fwd_user[TUSER_SRC_HI:TUSER_SRC_LO] = C_DEFAULT_SRC_PORT;
    end
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state <= IDLE;
            beats <= '0;
        end else if (accept) begin
            state <= s_axis_tlast ? IDLE : ((state == DROP || trunc) ? DROP : PASS);
            beats <= (state == DROP) ? '0 : beat_num;
        end
    end
    nf10_axis_skid #(
        .DATA_WIDTH (C_AXIS_DATA_WIDTH),
        .TUSER_WIDTH(C_AXIS_TUSER_WIDTH)
    ) u_skid (
        .clk     (axi_aclk),
        .rst     (axi_reset),
        .s_tdata (s_axis_tdata),
        .s_tstrb (s_axis_tstrb),
        .s_tuser (fwd_user),
        .s_tvalid(s_axis_tvalid && state != DROP),
        .s_tlast (s_axis_tlast || trunc),
        .s_tready(skid_ready),
        .m_tdata (m_axis_tdata),
        .m_tstrb (m_axis_tstrb),
        .m_tuser (m_axis_tuser),
        .m_tvalid(m_axis_tvalid),
        .m_tlast (m_axis_tlast),
        .m_tready(m_axis_tready)
    );
`ifdef NF10_RX_GUARD_STATS_EN
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            pkt_count   <= '0;
            trunc_count <= '0;
        end else begin
            pkt_count   <= pkt_count + 32'(m_axis_tvalid && m_axis_tready && m_axis_tlast);
            trunc_count <= trunc_count + 32'(trunc);
        end
    end
`endif
endmodule

// File: tb/tb_nf10_axis_rx_guard.sv
// tb_nf10_axis_rx_guard: randomized stimulus checked every cycle against a queue-based packet model.
module tb_nf10_axis_rx_guard;
    localparam int D = 64;
    localparam int U = 32;
    localparam int M = 48;
    typedef struct packed {
        logic [D-1:0]   d;
        logic [D/8-1:0] s;
        logic [U-1:0]   u;
        logic           l;
    } beat_t;
    logic           clk = 1'b0, rst = 1'b1;
    logic [D-1:0]   s_tdata = '0, m_tdata;
    logic [D/8-1:0] s_tstrb = '0, m_tstrb;
    logic [U-1:0]   s_tuser = '0, m_tuser;
    logic           s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic           m_tvalid, m_tlast, m_tready = 1'b1;
`ifdef NF10_RX_GUARD_STATS_EN
    logic [31:0]    pkt_count, trunc_count;
`endif
    beat_t      q[$];
    beat_t      nb;
    int         pos = 0, mp = 0, mt = 0, vec = 0, mis = 0, out_beats = 0, mode = 0;
    bit         drop = 0, acc = 0, out_first = 1;
    logic [7:0] first_src = 8'h00;

    always #5 clk = ~clk;

    nf10_axis_rx_guard #(
        .C_AXIS_DATA_WIDTH (D),
        .C_AXIS_TUSER_WIDTH(U),
        .C_MAX_BEATS       (M),
        .C_DEFAULT_SRC_PORT(8'h40)
    ) dut (
        .axi_aclk     (clk),
        .axi_reset    (rst),
        .s_axis_tdata (s_tdata),
        .s_axis_tstrb (s_tstrb),
        .s_axis_tuser (s_tuser),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tlast (s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tstrb (m_tstrb),
        .m_axis_tuser (m_tuser),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tlast (m_tlast),
        .m_axis_tready(m_tready)
`ifdef NF10_RX_GUARD_STATS_EN
        ,
        .pkt_count    (pkt_count),
        .trunc_count  (trunc_count)
`endif
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        vec++;
        if (a !== e) begin
            mis++;
            $display("FAIL %s: got %0h, expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // Model: queue holds accepted-but-undelivered beats; the buffer has room while fewer than two are held.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            pos = 0; drop = 0; mp = 0; mt = 0; acc = 0; out_first = 1;
            chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
            chk("rst_s_tready", 64'(s_tready), 64'd0);
        end else begin
            bit rdy;
            rdy = drop || q.size() < 2;
            chk("s_tready", 64'(s_tready), 64'(rdy));
            chk("m_tvalid", 64'(m_tvalid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("m_tdata", 64'(m_tdata), 64'(q[0].d));
                chk("m_tstrb", 64'(m_tstrb), 64'(q[0].s));
                chk("m_tuser", 64'(m_tuser), 64'(q[0].u));
                chk("m_tlast", 64'(m_tlast), 64'(q[0].l));
            end
`ifdef NF10_RX_GUARD_STATS_EN
            chk("pkt_count", 64'(pkt_count), 64'(mp));
            chk("trunc_count", 64'(trunc_count), 64'(mt));
`endif
            if (m_tready && q.size() > 0) begin
                out_beats++;
                if (out_first) first_src = q[0].u[23:16];
                out_first = q[0].l;
                if (q[0].l) mp++;
                void'(q.pop_front());
            end
            acc = s_tvalid && rdy;
            if (acc && drop) begin
                if (s_tlast) drop = 0;
            end else if (acc) begin
                pos++;
                nb = '{d: s_tdata, s: s_tstrb, u: s_tuser, l: s_tlast || pos == M};
                if (pos == 1 && s_tuser[23:16] == 8'h00) nb.u[23:16] = 8'h40;
                q.push_back(nb);
                if (s_tlast) pos = 0;
                else if (pos == M) begin
                    drop = 1; pos = 0; mt++;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        m_tready = (mode == 0) ? 1'b1 : (mode == 1) ? ~m_tready : 1'($urandom_range(1));
    end

    task automatic send_pkt(input int n, input logic [7:0] src, input int vpct, input int stop_after);
        for (int b = 0; b < n && b < stop_after; b++) begin
            int t;
            while (int'($urandom_range(99)) >= vpct) begin
                s_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_tvalid = 1'b1;
            s_tdata  = {$urandom, $urandom};
            s_tstrb  = 8'($urandom);
            s_tuser  = $urandom;
            s_tuser[23:16] = src;
            s_tlast  = (b == n - 1);
            t = 0;
            do begin
                @(posedge clk);
                #1;
                t++;
            end while (!acc && t < 200);
            if (!acc) begin
                mis++;
                $display("FAIL accept_timeout: beat %0d not accepted, got no handshake, expected one", b);
            end
        end
        if (stop_after >= n) s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() > 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (q.size() > 0) begin
            mis++;
            $display("FAIL drain_timeout: got %0d beats pending, expected 0", q.size());
        end
    endtask

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        // three 4-beat packets, src zero
        base = out_beats;
        for (int i = 0; i < 3; i++) send_pkt(4, 8'h00, 100, 99);
        drain();
        chk("t1_beats", 64'(out_beats - base), 64'd12);
        chk("t1_pkts", 64'(mp), 64'd3);
        chk("t1_src", 64'(first_src), 64'h40);
`ifdef NF10_RX_GUARD_STATS_EN
        chk("t1_pkt_count", 64'(pkt_count), 64'd3);
`endif
        // oversize packet truncated at M beats, then a normal one
        base = out_beats;
        send_pkt(60, 8'h05, 100, 99);
        drain();
        chk("t2_beats", 64'(out_beats - base), 64'd48);
        chk("t2_trunc", 64'(mt), 64'd1);
        base = out_beats;
        send_pkt(5, 8'h07, 100, 99);
        drain();
        chk("t2_next_beats", 64'(out_beats - base), 64'd5);
        chk("t2_next_src", 64'(first_src), 64'h07);
        // exactly M beats with tlast on the last
        base = out_beats;
        send_pkt(M, 8'h00, 100, 99);
        drain();
        chk("t3_beats", 64'(out_beats - base), 64'd48);
        chk("t3_trunc", 64'(mt), 64'd1);
`ifdef NF10_RX_GUARD_STATS_EN
        chk("t3_trunc_count", 64'(trunc_count), 64'd1);
`endif
        // toggling downstream ready
        mode = 1;
        base = out_beats;
        send_pkt(20, 8'h11, 100, 99);
        send_pkt(20, 8'h00, 100, 99);
        drain();
        chk("t4_beats", 64'(out_beats - base), 64'd40);
        // back-to-back single-beat packets
        mode = 0;
        base = mp;
        for (int i = 0; i < 10; i++) send_pkt(1, 8'h01, 100, 99);
        drain();
        chk("t5_pkts", 64'(mp - base), 64'd10);
        chk("t5_src", 64'(first_src), 64'h01);
        // random traffic
        mode = 2;
        for (int i = 0; i < 30; i++)
            send_pkt(int'($urandom_range(60, 1)), ($urandom_range(1) == 1) ? 8'h00 : 8'($urandom), 70, 99);
        drain();
        // reset in the middle of a 10-beat packet
        mode = 0;
        send_pkt(10, 8'h00, 100, 3);
        rst = 1'b1;
        s_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        send_pkt(2, 8'h00, 100, 99);
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("t7_pkts", 64'(mp), 64'd1);
`ifdef NF10_RX_GUARD_STATS_EN
        chk("t7_pkt_count", 64'(pkt_count), 64'd1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule

// File: doc/nf10_axis_rx_guard.md
NF10_AXIS_RX_GUARD -- requirements
Module: nf10_axis_rx_guard

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 256: tdata width in bits; tstrb width is C_AXIS_DATA_WIDTH/8.
REQ-002 SHALL have parameter C_AXIS_TUSER_WIDTH, default 128: tuser width in bits.
REQ-003 SHALL have parameter C_MAX_BEATS, default 48: maximum number of beats forwarded per packet (1536 B at 256 bits).
REQ-004 SHALL have parameter C_DEFAULT_SRC_PORT, default 8'h40: source-port value substituted for tuser[23:16] when that field is zero.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: axi_aclk in 1, the single clock; axi_reset in 1, asynchronous active-high reset.
REQ-006 SHALL have slave port s_axis_tdata/tstrb/tuser/tvalid/tlast in and s_axis_tready out, widths per REQ-001/002; fed by the 10G interface m_axis port.
REQ-007 SHALL have master port m_axis_tdata/tstrb/tuser/tvalid/tlast out and m_axis_tready in, with matching widths.
REQ-008 SHALL have outputs pkt_count out 32 (packets completed on m_axis) and trunc_count out 32 (packets truncated), present only per REQ-021.

Function
REQ-009 SHALL register all m_axis outputs through a two-entry skid buffer: one cycle latency; full throughput under continuous tready.
REQ-010 SHALL assert s_axis_tready exactly when the skid buffer has a free entry, except in state DROP (REQ-014).
REQ-011 SHALL implement FSM states IDLE (awaiting first beat), PASS (mid-packet), DROP (discarding overflow).
REQ-012 SHALL, on an accepted first beat (IDLE), replace tuser[23:16] with C_DEFAULT_SRC_PORT if it is zero, pass all other tuser bits unchanged, and load a 1 into the beat counter; later beats SHALL pass tuser unmodified.
REQ-013 SHALL increment the beat counter (width clog2(C_MAX_BEATS)+1) on each accepted beat; a beat with tlast SHALL return the FSM to IDLE.
REQ-014 SHALL, when the accepted beat is number C_MAX_BEATS and tlast=0, forward it with m_axis_tlast forced to 1, enter DROP, and count it as truncated.
REQ-015 SHALL, in DROP, hold s_axis_tready=1 and discard beats; no m_axis output SHALL be produced. The beat carrying tlast SHALL return the FSM to IDLE.
REQ-016 SHALL treat a single-beat packet (first beat with tlast) as IDLE->IDLE, so that a new packet is accepted on the next cycle.
REQ-017 SHALL pass a packet of exactly C_MAX_BEATS beats whose last beat has tlast=1 without truncation.
REQ-018 SHALL leave tdata and tstrb unmodified on every forwarded beat.

Reset
REQ-019 SHALL, on asserting axi_reset at any time including mid-packet, clear the skid buffer, the FSM (to IDLE), the beat counter and both counters; m_axis_tvalid=0, s_axis_tready=0 while reset is asserted.
REQ-020 SHALL drive s_axis_tready=1 on the first cycle after reset deassertion; a partial packet in progress at reset SHALL not be completed.

Configuration
REQ-021 Macro NF10_RX_GUARD_STATS_EN: when defined, the ports pkt_count and trunc_count exist and are wrapping 32-bit counters. pkt_count SHALL increment on each m_axis tvalid&tready&tlast. trunc_count SHALL increment on each REQ-014 event. When undefined, the ports and counter logic SHALL be absent, and the datapath SHALL be identical.

Structure
REQ-022 SHALL place the FSM state enum, the tuser field offsets (len [15:0], src [23:16], dst [31:24]) and the default widths in package nf10_axis_pkg.
REQ-023 SHALL instantiate the skid buffer as sub-module nf10_axis_skid, parameterised by data and tuser widths.

Verification
REQ-024 Three 4-beat packets with src=0, tready=1 -> identical beats out at 1-cycle latency, with first-beat tuser[23:16]=8'h40 and pkt_count=3.
REQ-025 A 60-beat packet with C_MAX_BEATS=48 -> 48 beats out, with beat 48 tlast=1; 12 beats dropped with tready=1; trunc_count=1; the next packet passes intact.
REQ-026 Continuous input with m_axis_tready toggling 1010... -> no beat lost or duplicated; s_axis_tready deasserts only when the skid buffer is full.
REQ-027 Single-beat packets back-to-back with src=8'h01 -> one output per cycle, src field unchanged at 8'h01.
REQ-028 axi_reset pulsed at beat 3 of a 10-beat packet -> outputs cleared within reset; after release, a fresh 2-beat packet is forwarded and pkt_count=1.
REQ-029 Exactly 48-beat packet with tlast on beat 48 -> forwarded whole; trunc_count stays 0.
